// File: rtl/act_seq_ctrl_q15.sv
// Q1.15 activation sequencer: streams N_ELEM feature words through a shared
// sigmoid-approx / pass-through datapath into a result buffer, counting saturated inputs.
module act_seq_ctrl_q15 #(
  parameter int unsigned N_ELEM = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     act_sel,
  input  logic [ADDR_W-1:0]        rd_base,
  input  logic [ADDR_W-1:0]        wr_base,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [15:0]       rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [15:0]       wr_data,
  output logic [ADDR_W-1:0]        sat_cnt
);

  localparam int unsigned CNT_W = $clog2(N_ELEM + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              r_state,   w_state_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_rd_en,   w_rd_en_nxt;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic                r_rd_vld,  w_rd_vld_nxt;
  logic                r_wr_en,   w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic signed [15:0]  r_wr_data, w_wr_data_nxt;
  logic [ADDR_W-1:0]   r_sat_cnt, w_sat_cnt_nxt;
  logic [ADDR_W-1:0]   r_wr_base, w_wr_base_nxt;
  logic                r_act_sel, w_act_sel_nxt;
  logic [CNT_W-1:0]    r_rd_cnt,  w_rd_cnt_nxt;
  logic [CNT_W-1:0]    r_wr_cnt,  w_wr_cnt_nxt;

  logic                w_sat_lo;
  logic                w_sat_hi;
  logic signed [15:0]  w_half;
  logic signed [15:0]  w_sig;
  logic signed [15:0]  w_act;

  // Shared activation datapath on the registered read data
  always_comb begin
    w_sat_lo = (rd_data <= 16'shC000);
    w_sat_hi = (rd_data >= 16'sh4000);
    w_half   = rd_data >>> 1;
    if (w_sat_lo)      w_sig = 16'sh2000;
    else if (w_sat_hi) w_sig = 16'sh6000;
    else               w_sig = 16'sh4000 + w_half;
    w_act = r_act_sel ? rd_data : w_sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_rd_vld  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_sat_cnt <= '0;
      r_wr_base <= '0;
      r_act_sel <= 1'b0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_vld  <= w_rd_vld_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_sat_cnt <= w_sat_cnt_nxt;
      r_wr_base <= w_wr_base_nxt;
      r_act_sel <= w_act_sel_nxt;
      r_rd_cnt  <= w_rd_cnt_nxt;
      r_wr_cnt  <= w_wr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_vld_nxt  = r_rd_en;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_sat_cnt_nxt = r_sat_cnt;
    w_wr_base_nxt = r_wr_base;
    w_act_sel_nxt = r_act_sel;
    w_rd_cnt_nxt  = r_rd_cnt;
    w_wr_cnt_nxt  = r_wr_cnt;

    // Write stage: one result per valid read word, one cycle after the data arrives
    if (r_rd_vld) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = r_wr_base + ADDR_W'(r_wr_cnt);
      w_wr_data_nxt = w_act;
      w_wr_cnt_nxt  = r_wr_cnt + CNT_W'(1);
      w_sat_cnt_nxt = r_sat_cnt + ADDR_W'(w_sat_lo | w_sat_hi);
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_READ;
          w_busy_nxt    = 1'b1;
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = rd_base;
          w_rd_cnt_nxt  = CNT_W'(1);
          w_wr_cnt_nxt  = '0;
          w_sat_cnt_nxt = '0;
          w_wr_base_nxt = wr_base;
          w_act_sel_nxt = act_sel;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (r_rd_cnt == CNT_W'(N_ELEM)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
          w_rd_cnt_nxt  = r_rd_cnt + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_wr_en && (r_wr_cnt == CNT_W'(N_ELEM))) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_act_seq_ctrl_q15.sv
// Directed bench for act_seq_ctrl_q15: a 9-element instance and a 1-element instance.
module tb_act_seq_ctrl_q15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        start = 1'b0, act_sel = 1'b0;
  logic [3:0]  rd_base = '0, wr_base = '0;
  logic        busy, done, rd_en, wr_en;
  logic [3:0]  rd_addr, wr_addr, sat_cnt;
  logic signed [15:0] rd_data = '0;
  logic signed [15:0] wr_data;

  logic        start1 = 1'b0, act_sel1 = 1'b0;
  logic [3:0]  rd_base1 = '0, wr_base1 = '0;
  logic        busy1, done1, rd_en1, wr_en1;
  logic [3:0]  rd_addr1, wr_addr1, sat_cnt1;
  logic signed [15:0] rd_data1 = '0;
  logic signed [15:0] wr_data1;

  logic [15:0] fmem [16];
  logic [15:0] fmem1 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic        c_rd_en [64], c_wr_en [64], c_busy [64], c_done [64];
  logic [3:0]  c_rd_addr [64], c_wr_addr [64], c_sat [64];
  logic [15:0] c_wr_data [64];

  logic [15:0] in1  [9] = '{16'h0000, 16'h2000, 16'hE000, 16'h4000, 16'hC000,
                            16'h7FFF, 16'h8000, 16'h3FFF, 16'hC001};
  logic [15:0] exp1 [9] = '{16'h4000, 16'h5000, 16'h3000, 16'h6000, 16'h2000,
                            16'h6000, 16'h2000, 16'h5FFF, 16'h2000};
  logic [3:0]  ra3  [9] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0]  wa3  [9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};

  act_seq_ctrl_q15 #(.N_ELEM(9), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .act_sel(act_sel),
    .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sat_cnt(sat_cnt)
  );

  act_seq_ctrl_q15 #(.N_ELEM(1), .ADDR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .act_sel(act_sel1),
    .rd_base(rd_base1), .wr_base(wr_base1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .sat_cnt(sat_cnt1)
  );

  // Feature buffers with a registered read port
  always @(posedge clk) if (rd_en)  rd_data  <= fmem[rd_addr];
  always @(posedge clk) if (rd_en1) rd_data1 <= fmem1;

  task automatic clear_fmem();
    for (int i = 0; i < 16; i++) fmem[i] = 16'h0000;
  endtask

  task automatic launch(input logic sel, input logic [3:0] rb, input logic [3:0] wb);
    @(negedge clk);
    start = 1'b1; act_sel = sel; rd_base = rb; wr_base = wb;
  endtask

  // Records cycles 1..ncyc after the start edge; scrambles job inputs after acceptance
  task automatic capture(input int ncyc, input bit hold);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      c_rd_en[k] = rd_en; c_rd_addr[k] = rd_addr;
      c_wr_en[k] = wr_en; c_wr_addr[k] = wr_addr; c_wr_data[k] = wr_data;
      c_busy[k] = busy; c_done[k] = done; c_sat[k] = sat_cnt;
      if (!hold && k == 1) begin
        start = 1'b0; act_sel = ~act_sel;
        rd_base = rd_base + 4'd3; wr_base = wr_base + 4'd5;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, sat_cnt} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, sat_cnt});
    end
    n_tests++;
    if ({busy1, done1, rd_en1, wr_en1, sat_cnt1} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_n1: got %h required 0", {busy1, done1, rd_en1, wr_en1, sat_cnt1});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sigmoid();
    clear_fmem();
    for (int i = 0; i < 9; i++) fmem[i] = in1[i];
    launch(1'b0, 4'd0, 4'd0);
    capture(14, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      n_tests++;
      if (c_rd_en[k] !== (k <= 9) || (k <= 9 && c_rd_addr[k] !== 4'(k - 1))) begin
        n_fail++;
        $display("FAIL sig_rd cyc%0d: got en=%b addr=%0d required en=%b addr=%0d",
                 k, c_rd_en[k], c_rd_addr[k], (k <= 9), k - 1);
      end
      n_tests++;
      if (c_wr_en[k] !== (k >= 3 && k <= 11) ||
          (k >= 3 && k <= 11 && (c_wr_addr[k] !== 4'(k - 3) || c_wr_data[k] !== exp1[k-3]))) begin
        n_fail++;
        $display("FAIL sig_wr cyc%0d: got en=%b addr=%0d data=%h required en=%b",
                 k, c_wr_en[k], c_wr_addr[k], c_wr_data[k], (k >= 3 && k <= 11));
      end
      n_tests++;
      if (c_busy[k] !== (k <= 11) || c_done[k] !== (k == 12)) begin
        n_fail++;
        $display("FAIL sig_busy_done cyc%0d: got busy=%b done=%b required busy=%b done=%b",
                 k, c_busy[k], c_done[k], (k <= 11), (k == 12));
      end
    end
    n_tests++;
    if (c_sat[12] !== 4'd4 || c_sat[14] !== 4'd4) begin
      n_fail++;
      $display("FAIL sig_sat_cnt: got %0d/%0d required 4", c_sat[12], c_sat[14]);
    end
  endtask

  task automatic test_passthrough();
    launch(1'b1, 4'd0, 4'd0);
    capture(13, 1'b0);
    n_tests++;
    if (c_sat[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL pass_sat_clear: got %0d required 0", c_sat[1]);
    end
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (c_wr_en[i+3] !== 1'b1 || c_wr_data[i+3] !== in1[i]) begin
        n_fail++;
        $display("FAIL pass_data i%0d: got en=%b data=%h required %h",
                 i, c_wr_en[i+3], c_wr_data[i+3], in1[i]);
      end
    end
    n_tests++;
    if (c_done[12] !== 1'b1 || c_sat[12] !== 4'd4) begin
      n_fail++;
      $display("FAIL pass_done_sat: got done=%b sat=%0d required 1/4", c_done[12], c_sat[12]);
    end
  endtask

  task automatic test_addr_wrap();
    clear_fmem();
    for (int i = 0; i < 9; i++) fmem[ra3[i]] = 16'h1100 + 16'(i);
    launch(1'b1, 4'd12, 4'd10);
    capture(13, 1'b0);
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (c_rd_addr[i+1] !== ra3[i] || c_wr_addr[i+3] !== wa3[i] ||
          c_wr_data[i+3] !== 16'h1100 + 16'(i)) begin
        n_fail++;
        $display("FAIL wrap i%0d: got rd=%0d wr=%0d data=%h required rd=%0d wr=%0d data=%h",
                 i, c_rd_addr[i+1], c_wr_addr[i+3], c_wr_data[i+3],
                 ra3[i], wa3[i], 16'h1100 + 16'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    clear_fmem();
    for (int i = 0; i < 9; i++) fmem[i] = in1[i];
    launch(1'b0, 4'd0, 4'd0);
    capture(38, 1'b1);
    ndone = 0;
    for (int k = 1; k <= 38; k++) begin
      if (k <= 36 && c_done[k] === 1'b1) ndone++;
      n_tests++;
      if (c_done[k] !== (k % 12 == 0) || c_rd_en[k] !== (((k - 1) % 12) < 9)) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got done=%b rd_en=%b required done=%b rd_en=%b",
                 k, c_done[k], c_rd_en[k], (k % 12 == 0), (((k - 1) % 12) < 9));
      end
    end
    n_tests++;
    if (ndone != 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 3", ndone);
    end
    n_tests++;
    if (c_wr_data[15] !== 16'h4000 || c_sat[24] !== 4'd4) begin
      n_fail++;
      $display("FAIL b2b_job2: got data=%h sat=%0d required 4000/4", c_wr_data[15], c_sat[24]);
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset_midjob();
    bit bad;
    clear_fmem();
    fmem[0] = 16'h7FFF; fmem[1] = 16'h8000; fmem[2] = 16'h4000; fmem[3] = 16'hC000;
    launch(1'b0, 4'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    n_tests++;
    if (sat_cnt !== 4'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got sat=%0d busy=%b required 3/1", sat_cnt, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rd_en, wr_en, done, busy, sat_cnt} !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_midjob: got rd=%b wr=%b done=%b busy=%b sat=%0d required 0",
               rd_en, wr_en, done, busy, sat_cnt);
    end
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_no_partial: got activity after reset required none");
    end
    clear_fmem();
    for (int i = 0; i < 8; i++) fmem[i] = 16'h1000;
    fmem[8] = 16'h8000;
    launch(1'b0, 4'd0, 4'd0);
    capture(13, 1'b0);
    n_tests++;
    if (c_wr_data[3] !== 16'h4800 || c_wr_data[11] !== 16'h2000 ||
        c_done[12] !== 1'b1 || c_sat[12] !== 4'd1) begin
      n_fail++;
      $display("FAIL rst_rejob: got d0=%h d8=%h done=%b sat=%0d required 4800/2000/1/1",
               c_wr_data[3], c_wr_data[11], c_done[12], c_sat[12]);
    end
  endtask

  task automatic test_single_elem();
    fmem1 = 16'hC000;
    @(negedge clk);
    start1 = 1'b1; act_sel1 = 1'b0; rd_base1 = 4'd5; wr_base1 = 4'd7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      n_tests++;
      if (rd_en1 !== (k == 1) || wr_en1 !== (k == 3) || done1 !== (k == 4) || busy1 !== (k <= 3) ||
          (k == 1 && rd_addr1 !== 4'd5) ||
          (k == 3 && (wr_addr1 !== 4'd7 || wr_data1 !== 16'sh2000)) ||
          (k == 4 && sat_cnt1 !== 4'd1)) begin
        n_fail++;
        $display("FAIL n1 cyc%0d: got rd=%b@%0d wr=%b@%0d data=%h done=%b busy=%b sat=%0d",
                 k, rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, done1, busy1, sat_cnt1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sigmoid();
    test_passthrough();
    test_addr_wrap();
    test_back_to_back();
    test_reset_midjob();
    test_single_elem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
